// File: rtl/key_sequencer.sv
// rtl/key_sequencer.sv - keypad-to-ALU operand/operator sequencer for a hex calculator
module key_sequencer #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4:0]            i_key_data,
  input  logic                  i_key_valid,
  output logic                  o_key_ready,
  output logic [4*DIGITS-1:0]   o_alu_a,
  output logic [4*DIGITS-1:0]   o_alu_b,
  output logic [2:0]            o_alu_op,
  output logic                  o_alu_valid,
  input  logic                  i_alu_ready,
  input  logic [4*DIGITS-1:0]   i_alu_result,
  input  logic                  i_alu_error,
  input  logic                  i_alu_result_valid,
  output logic [4*DIGITS-1:0]   o_display,
  output logic                  o_error
);
  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);

  typedef enum logic [2:0] {
    ENTER_A, OP_SEL, ENTER_B, ALU_REQ, ALU_WAIT, RESULT, ERROR
  } state_t;

  state_t         state, state_n;
  logic [W-1:0]   a, a_n, b, b_n;
  logic [2:0]     op, op_n, pend_op, pend_op_n;
  logic           pend, pend_n, err_n;
  logic [CW-1:0]  cnt, cnt_n;

  logic           key_fire, is_digit, is_ac, is_op, is_eq, cnt_full;
  logic [W-1:0]   digit_w;

  assign key_fire = i_key_valid && o_key_ready;
  assign is_digit = !i_key_data[4];
  assign is_ac    = (i_key_data == 5'h10);
  assign is_op    = (i_key_data >= 5'h11) && (i_key_data <= 5'h14);
  assign is_eq    = (i_key_data == 5'h15);
  assign cnt_full = (cnt == CW'(DIGITS));
  assign digit_w  = {{(W-4){1'b0}}, i_key_data[3:0]};

  assign o_alu_a  = a;
  assign o_alu_b  = b;
  assign o_alu_op = op;

  always_comb begin
    state_n   = state;
    a_n       = a;
    b_n       = b;
    op_n      = op;
    pend_n    = pend;
    pend_op_n = pend_op;
    cnt_n     = cnt;
    err_n     = o_error;
    if (key_fire && is_ac) begin
      state_n   = ENTER_A;
      a_n       = '0;
      b_n       = '0;
      op_n      = '0;
      pend_n    = 1'b0;
      pend_op_n = '0;
      cnt_n     = '0;
      err_n     = 1'b0;
    end else begin
      case (state)
        ENTER_A: if (key_fire) begin
          if (is_digit && !cnt_full) begin
            a_n   = {a[W-5:0], i_key_data[3:0]};
            cnt_n = cnt + CW'(1);
          end else if (is_op) begin
            op_n    = i_key_data[2:0];
            state_n = OP_SEL;
          end
        end
        OP_SEL: if (key_fire) begin
          if (is_op) begin
            op_n = i_key_data[2:0];
          end else if (is_digit) begin
            b_n     = digit_w;
            cnt_n   = CW'(1);
            state_n = ENTER_B;
          end
        end
        ENTER_B: if (key_fire) begin
          if (is_digit && !cnt_full) begin
            b_n   = {b[W-5:0], i_key_data[3:0]};
            cnt_n = cnt + CW'(1);
          end else if (is_eq) begin
            pend_n  = 1'b0;
            state_n = ALU_REQ;
          end else if (is_op) begin
            // operator terminating B chains into the next operation
            pend_n    = 1'b1;
            pend_op_n = i_key_data[2:0];
            state_n   = ALU_REQ;
          end
        end
        ALU_REQ: if (i_alu_ready) state_n = ALU_WAIT;
        ALU_WAIT: if (i_alu_result_valid) begin
          if (i_alu_error) begin
            err_n   = 1'b1;
            state_n = ERROR;
          end else begin
            a_n = i_alu_result;
            if (pend) begin
              op_n    = pend_op;
              pend_n  = 1'b0;
              state_n = OP_SEL;
            end else begin
              state_n = RESULT;
            end
          end
        end
        RESULT: if (key_fire) begin
          if (is_digit) begin
            a_n     = digit_w;
            cnt_n   = CW'(1);
            state_n = ENTER_A;
          end else if (is_op) begin
            op_n    = i_key_data[2:0];
            state_n = OP_SEL;
          end
        end
        default: ;
      endcase
    end
  end

  // outputs are registered from next-state values so they line up with state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ENTER_A;
      a           <= '0;
      b           <= '0;
      op          <= '0;
      pend        <= 1'b0;
      pend_op     <= '0;
      cnt         <= '0;
      o_error     <= 1'b0;
      o_display   <= '0;
      o_alu_valid <= 1'b0;
      o_key_ready <= 1'b0;
    end else begin
      state       <= state_n;
      a           <= a_n;
      b           <= b_n;
      op          <= op_n;
      pend        <= pend_n;
      pend_op     <= pend_op_n;
      cnt         <= cnt_n;
      o_error     <= err_n;
      o_alu_valid <= (state_n == ALU_REQ);
      o_key_ready <= (state_n != ALU_REQ) && (state_n != ALU_WAIT);
      case (state_n)
        ENTER_B, ALU_REQ: o_display <= b_n;
        ERROR:            o_display <= '0;
        default:          o_display <= a_n;
      endcase
    end
  end
endmodule
